fetch_stage: RTL

- Instruction fetch stage; sits directly upstream of the IF/ID pipeline register bank, which is built from the team's N-bit register block.
- Owns the program counter and drives the instruction-memory address.
- Assembles 16-bit and 32-bit instructions (opcode word plus immediate word) and emits one complete instruction per valid beat.
- Supports decode-stage stall and execute-stage redirect (branch/jump/flush).

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_pc_register.sv | 36 +++
 rtl/fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: state encoding and default widths/positions.
package fetch_stage_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned PC_W_DEF         = 32;
  localparam int unsigned IMM_BIT_DEF      = 15;
  localparam int unsigned RESET_VECTOR_DEF = 0;

  typedef enum logic {
    ST_OPC = 1'b0,
    ST_IMM = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register: hold, increment, or load a redirect target.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            load_en_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Increment wraps modulo 2^PC_W by construction.
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = redirect_i ? redirect_pc_i : pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_W'(RESET_VECTOR);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, assembles 16/32-bit instructions, honours stall and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned IMM_BIT      = IMM_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] hold_opc_q, hold_opc_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
  logic              valid_q, valid_d;
  logic              pc_en;
  logic [PC_W-1:0]   pc;

  pc_register #(
    .PC_W         (PC_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk           (clk),
    .rst_ni        (reset),
    .load_en_i     (pc_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    hold_opc_d = hold_opc_q;
    instr_pc_d = instr_pc_q;
    hold_pc_d  = hold_pc_q;
    valid_d    = valid_q;
    pc_en      = 1'b0;

    // Redirect beats stall: a flush must never be held off by decode back-pressure.
    if (redirect) begin
      pc_en      = 1'b1;
      state_d    = ST_OPC;
      valid_d    = 1'b0;
      hold_opc_d = '0;
    end else if (!stall) begin
      pc_en = 1'b1;
      unique case (state_q)
        ST_OPC: begin
          if (imem_data[IMM_BIT]) begin
            hold_opc_d = imem_data;
            hold_pc_d  = pc;
            valid_d    = 1'b0;
            state_d    = ST_IMM;
          end else begin
            instr_d    = imem_data;
            imm_d      = '0;
            instr_pc_d = pc;
            valid_d    = 1'b1;
          end
        end
        ST_IMM: begin
          instr_d    = hold_opc_q;
          imm_d      = imem_data;
          instr_pc_d = hold_pc_q;
          valid_d    = 1'b1;
          state_d    = ST_OPC;
        end
        default: state_d = ST_OPC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_OPC;
      instr_q    <= '0;
      imm_q      <= '0;
      hold_opc_q <= '0;
      instr_pc_q <= '0;
      hold_pc_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      hold_opc_q <= hold_opc_d;
      instr_pc_q <= instr_pc_d;
      hold_pc_q  <= hold_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign imm         = imm_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule
